// File: rtl/spi_tx_drain.sv
// Purpose : SPI mode-0 master that pops bytes from the upstream fifo_mxn and shifts them out MSB-first.
// Latency : first SCLK rise 4+clkdiv cycles after a pop decision; byte_done 4+2*dw*clkdiv cycles after it.
// Backpressure: pops only when enable=1 and the FIFO flags data; enable is sampled only between bytes.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   enable          - level; allows starting a new byte (sampled in IDLE and DONE only)
//   fifo_empty      - FIFO "empty" flag, 1 = data available
//   fifo_odat       - FIFO registered read data, valid the cycle after the pop falling edge
//   fifo_oen        - pop strobe; the FIFO pops on its high->low transition
//   sclk/mosi/cs_n  - SPI bus (CPOL=0, CPHA=0)
//   busy            - high whenever the controller is not idle
//   byte_done       - one-cycle pulse after the last SCLK falling edge of each byte

module spi_tx_drain #(
    parameter int dw     = 8,
    parameter int clkdiv = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic [dw-1:0] fifo_odat,
    output logic          fifo_oen,
    output logic          sclk,
    output logic          mosi,
    output logic          cs_n,
    output logic          busy,
    output logic          byte_done
);

    localparam int CNT_W = (clkdiv > 1) ? $clog2(clkdiv) : 1;
    localparam int BIT_W = $clog2(dw + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clkdiv - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_HI,
        S_POP_LO,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [dw-1:0]    shreg_q,  shreg_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic             sclk_q,   sclk_d;
    logic             mosi_q,   mosi_d;
    logic             cs_n_q,   cs_n_d;
    logic             oen_q,    oen_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        hcnt_d   = hcnt_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        oen_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (enable && fifo_empty) begin
                    state_d = S_POP_HI;
                    oen_d   = 1'b1;
                end
            end
            // oen drops here; the FIFO reacts to that falling edge.
            S_POP_HI: state_d = S_POP_LO;
            // odat is refreshed by the FIFO at the end of this cycle.
            S_POP_LO: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d  = fifo_odat;
                bitcnt_d = BIT_W'(dw);
                hcnt_d   = '0;
                cs_n_d   = 1'b0;
                mosi_d   = fifo_odat[dw-1];
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                if (hcnt_q == CNT_MAX) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // rising edge: slave samples the current bit
                        bitcnt_d = bitcnt_q - 1'b1;
                    end else if (bitcnt_q != '0) begin
                        // falling edge with bits left: present the next one
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_d[dw-1];
                    end else begin
                        // falling edge after the last rise closes the byte
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                sclk_d = 1'b0;
                if (enable && fifo_empty) begin
                    // burst: keep cs_n low across the pop gap
                    state_d = S_POP_HI;
                    oen_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            hcnt_q   <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            oen_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            hcnt_q   <= hcnt_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            oen_q    <= oen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fifo_oen  = oen_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign byte_done = done_q;

endmodule

// File: tb/tb_spi_tx_drain.sv
// Bench for spi_tx_drain: a queue-based FIFO model feeds a clkdiv=2 instance, an SPI
// monitor rebuilds bytes from SCLK rises and scores them against the pushed order;
// a second clkdiv=1 instance is driven directly for the fastest-clock case.
module tb_spi_tx_drain;

    localparam int CLKDIV0 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance 0 (clkdiv=2) with FIFO model
    logic       enable     = 1'b0;
    logic       fifo_empty = 1'b0;
    logic [7:0] fifo_odat  = 8'h00;
    logic       fifo_oen, sclk, mosi, cs_n, busy, byte_done;

    // instance 1 (clkdiv=1), driven directly
    logic       en1   = 1'b0;
    logic       emp1  = 1'b0;
    logic [7:0] odat1 = 8'h96;
    logic       o1_oen, o1_sclk, o1_mosi, o1_cs_n, o1_busy, o1_done;

    spi_tx_drain #(.dw(8), .clkdiv(CLKDIV0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_odat(fifo_odat),
        .fifo_oen(fifo_oen), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .byte_done(byte_done));

    spi_tx_drain #(.dw(8), .clkdiv(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .fifo_empty(emp1), .fifo_odat(odat1),
        .fifo_oen(o1_oen), .sclk(o1_sclk), .mosi(o1_mosi), .cs_n(o1_cs_n), .busy(o1_busy), .byte_done(o1_done));

    // FIFO model: pop on oen high->low, registered odat, flag 1 = data available
    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;
    logic [7:0] fq[$];
    logic       oen_prev = 1'b0;
    int         fifo_level = 0;

    always @(posedge clk) begin
        if (push_vld) fq.push_back(push_dat);
        if (oen_prev && !fifo_oen && fq.size() > 0) fifo_odat <= fq.pop_front();
        oen_prev   <= fifo_oen;
        fifo_empty <= (fq.size() != 0);
        fifo_level <= fq.size();
    end

    // scoreboard / monitor state
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap = 8'h00;
    logic [7:0] last_byte = 8'h00;
    int         nbits = 0;
    int         done_cnt = 0;
    int         oen_pulses = 0;
    int         last_done_cyc = 0;
    int         inv_bad = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_oen  = 1'b0;

    typedef struct {
        logic [7:0] dat;
        logic [7:0] exp_bits;
        int         done_cyc;
        int         rel_cyc;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout at cycle %0d", name, cyc);
    endtask

    // one clock, sampled 1 time unit after the edge, with the SPI monitor folded in
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            nbits = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                cap = {cap[6:0], mosi};
                nbits++;
            end
            if (sclk && cs_n) inv_bad++;
            if (sclk && !busy) inv_bad++;
            if (fifo_oen && prev_oen) inv_bad++;
            if (fifo_oen && !prev_oen) oen_pulses++;
            if (byte_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_byte = cap;
                check("bits_per_byte", nbits, 8);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h want none", cap);
                end else begin
                    check("byte_value", cap, exp_q.pop_front());
                end
                nbits = 0;
            end
        end
        prev_sclk = sclk;
        prev_oen  = fifo_oen;
    endtask

    task automatic push(input logic [7:0] d);
        push_vld = 1'b1;
        push_dat = d;
        exp_q.push_back(d);
        step();
        push_vld = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            if (byte_done) got = 1;
        end
        if (!got) timeout(name);
    endtask

    task automatic wait_idle(input int limit, input string name);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            if (!busy && !fifo_empty && cs_n) got = 1;
        end
        if (!got) timeout(name);
    endtask

    task automatic wait_bits(input int n, input int limit, input string name);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            if (nbits == n) got = 1;
        end
        if (!got) timeout(name);
    endtask

    initial begin
        int c0, bad_cyc, d0, o0, dc, nd, pushed, tog, d1;
        logic ps, pend, started, ps1;
        logic [7:0] cap1, want1;

        vecs[0] = '{8'hA5, 8'hA5, 36, 37};
        vecs[1] = '{8'h00, 8'h00, 36, 37};
        vecs[2] = '{8'hFF, 8'hFF, 36, 37};
        vecs[3] = '{8'h5A, 8'h5A, 36, 37};
        vecs[4] = '{8'h81, 8'h81, 36, 37};

        // ---- reset values
        rst = 1'b1;
        repeat (3) step();
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_oen", fifo_oen, 0);
        check("rst_busy", busy, 0);
        check("rst_done", byte_done, 0);
        check("rst1_cs_n", o1_cs_n, 1);
        check("rst1_oen", o1_oen, 0);
        rst = 1'b0;
        step();

        // ---- empty FIFO with enable high: stays idle
        enable = 1'b1;
        bad_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fifo_oen || !cs_n || busy) bad_cyc++;
        end
        check("empty_idle", bad_cyc, 0);
        enable = 1'b0;
        step();

        // ---- single-byte table, cycle-exact
        foreach (vecs[k]) begin
            push(vecs[k].dat);
            enable = 1'b1;
            c0 = cyc;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (c == 1) check("oen_c1", fifo_oen, 1);
                if (c == 2) check("oen_c2", fifo_oen, 0);
                if (c == 4) begin
                    check("cs_n_c4", cs_n, 0);
                    check("sclk_c4", sclk, 0);
                    check("msb_c4", mosi, vecs[k].exp_bits[7]);
                end
                if (c == 4 + CLKDIV0) check("first_rise", sclk, 1);
                if (c == vecs[k].rel_cyc - 1) check("cs_n_held", cs_n, 0);
                if (c == vecs[k].rel_cyc) check("cs_n_release", cs_n, 1);
            end
            enable = 1'b0;
            check("vec_byte", last_byte, vecs[k].exp_bits);
            check("vec_done_cyc", last_done_cyc - c0, vecs[k].done_cyc);
            check("vec_fifo_empty", fifo_level, 0);
        end

        // ---- burst of three bytes in one frame
        push(8'h01);
        push(8'hFF);
        push(8'h80);
        d0 = done_cnt;
        o0 = oen_pulses;
        enable = 1'b1;
        ps = sclk;
        pend = 1'b0;
        started = 1'b0;
        dc = 0;
        nd = 0;
        bad_cyc = 0;
        for (int i = 0; i < 400 && !(nd == 3 && !busy); i++) begin
            step();
            if (!cs_n) started = 1'b1;
            if (started && nd < 3 && cs_n) bad_cyc++;
            if (byte_done) begin
                dc = cyc;
                nd++;
                pend = (nd < 3);
            end
            if (pend && sclk && !ps) begin
                check("burst_gap", cyc - dc, 4 + CLKDIV0);
                pend = 1'b0;
            end
            ps = sclk;
        end
        enable = 1'b0;
        check("burst_cs_low", bad_cyc, 0);
        check("burst_done_pulses", done_cnt - d0, 3);
        check("burst_oen_pulses", oen_pulses - o0, 3);
        check("burst_busy_end", busy, 0);

        // ---- enable dropped mid-byte with a second byte queued
        push(8'hC3);
        push(8'h11);
        enable = 1'b1;
        wait_bits(3, 100, "drop_bits");
        enable = 1'b0;
        wait_done(200, "drop_done");
        check("drop_byte", last_byte, 8'hC3);
        repeat (10) step();
        check("drop_busy", busy, 0);
        check("drop_cs_n", cs_n, 1);
        check("drop_level", fifo_level, 1);
        enable = 1'b1;
        wait_done(200, "drop_second");
        check("drop_second_byte", last_byte, 8'h11);
        enable = 1'b0;
        wait_idle(50, "drop_idle");

        // ---- reset in the middle of a byte
        push(8'h5A);
        enable = 1'b1;
        wait_bits(5, 100, "rst_bits");
        rst = 1'b1;
        push_vld = 1'b1;
        push_dat = 8'h33;
        step();
        push_vld = 1'b0;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_oen", fifo_oen, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        void'(exp_q.pop_front());  // 0x5A was popped and is lost
        exp_q.push_back(8'h33);
        wait_done(200, "midrst_done");
        check("midrst_byte", last_byte, 8'h33);
        enable = 1'b0;
        wait_idle(50, "midrst_idle");

        // ---- clkdiv=1 instance, byte 0x96
        want1 = 8'h96;
        en1 = 1'b1;
        emp1 = 1'b1;
        ps1 = o1_sclk;
        tog = 0;
        d1 = 0;
        cap1 = 8'h00;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 1) begin
                check("div1_oen", o1_oen, 1);
                emp1 = 1'b0;
                en1 = 1'b0;
            end
            if (c == 4) check("div1_cs_n", o1_cs_n, 0);
            if (c >= 5 && c <= 20 && o1_sclk != ps1) tog++;
            if (o1_sclk && !ps1) cap1 = {cap1[6:0], o1_mosi};
            if (o1_done) d1 = c;
            ps1 = o1_sclk;
        end
        check("div1_toggles", tog, 16);
        check("div1_done_cyc", d1, 20);
        check("div1_byte", cap1, want1);
        check("div1_idle", o1_cs_n, 1);

        // ---- randomized traffic against the pushed-order scoreboard
        d0 = done_cnt;
        pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pushed < 30 && $urandom_range(0, 7) == 0) begin
                push_vld = 1'b1;
                push_dat = 8'($urandom_range(0, 255));
                exp_q.push_back(push_dat);
                pushed++;
            end
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            step();
            push_vld = 1'b0;
        end
        enable = 1'b1;
        wait_idle(4000, "rand_drain");
        check("rand_bytes", done_cnt - d0, pushed);
        check("rand_leftover", exp_q.size(), 0);
        check("invariants", inv_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
